// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: RISC-V func3
// width codes, FSM state encoding and the access-length helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Access length in bytes; only func3[1:0] encodes the width.
  function automatic logic [2:0] bytes_for(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Combinational sign/zero extension of the assembled little-endian load bytes.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] raw,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = raw;
    case (func3)
      F3_B:    ext_data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext_data = {{16{raw[15]}}, raw[15:0]};
      F3_W:    ext_data = raw;
      F3_BU:   ext_data = {24'h000000, raw[7:0]};
      F3_HU:   ext_data = {16'h0000, raw[15:0]};
      default: ext_data = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for a byte-wide data memory: serialises one load or
// store into per-byte accesses and returns the extended load result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W           = 8,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_t  state;
  logic [2:0]  func3_q;
  logic [31:0] store_q;
  logic [31:0] raw_q;
  logic [31:0] raw_next;
  logic [31:0] ext_data;
  logic [2:0]  nbytes_q;
  logic [1:0]  byte_idx;
  logic [1:0]  next_idx;
  logic        is_load_q;
  logic        last_byte;
  logic        req_bad;

  // Request legality: exactly one of load/store, a legal width code for the
  // direction, and natural alignment unless misaligned access is enabled.
  always_comb begin
    req_bad = 1'b0;
    if (is_load == is_store) begin
      req_bad = 1'b1;
    end else if (is_load && (func3 == 3'b011 || func3[2:1] == 2'b11)) begin
      req_bad = 1'b1;
    end else if (is_store && !(func3 == F3_B || func3 == F3_H || func3 == F3_W)) begin
      req_bad = 1'b1;
    end
    if (!ALLOW_MISALIGNED) begin
      if ((func3[1:0] == 2'b01 && addr[0]) ||
          (func3[1:0] == 2'b10 && addr[1:0] != 2'b00)) begin
        req_bad = 1'b1;
      end
    end
  end

  // The byte arriving this cycle is merged before extension so load_data
  // can be registered on the same edge that ends the transfer.
  always_comb begin
    raw_next = raw_q;
    raw_next[{byte_idx, 3'b000} +: 8] = mem_rdata;
  end

  assign next_idx  = byte_idx + 2'd1;
  assign last_byte = ({1'b0, byte_idx} == (nbytes_q - 3'd1));

  lsu_extend u_extend (
    .func3    (func3_q),
    .raw      (raw_next),
    .ext_data (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      load_data <= 32'h0;
      func3_q   <= 3'b000;
      store_q   <= 32'h0;
      raw_q     <= 32'h0;
      nbytes_q  <= 3'd1;
      byte_idx  <= 2'd0;
      is_load_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (req_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= XFER;
              func3_q   <= func3;
              store_q   <= store_data;
              nbytes_q  <= bytes_for(func3);
              is_load_q <= is_load;
              byte_idx  <= 2'd0;
              raw_q     <= 32'h0;
              mem_addr  <= addr;
              mem_re    <= is_load;
              mem_we    <= is_store;
              mem_wdata <= store_data[7:0];
            end
          end
        end

        XFER: begin
          if (is_load_q) begin
            raw_q <= raw_next;
          end
          if (last_byte) begin
            state  <= DONE;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            done   <= 1'b1;
            if (is_load_q) begin
              load_data <= ext_data;
            end
          end else begin
            byte_idx  <= next_idx;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= store_q[{next_idx, 3'b000} +: 8];
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          err    <= 1'b0;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one strict-alignment instance and one
// misaligned-capable instance, each with its own byte memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        is_load, is_store;
  logic [2:0]  func3;
  logic [7:0]  addr;
  logic [31:0] store_data;

  logic        busy_a, done_a, err_a, re_a, we_a;
  logic [31:0] ld_a;
  logic [7:0]  maddr_a, wdata_a, rdata_a;
  logic        busy_b, done_b, err_b, re_b, we_b;
  logic [31:0] ld_b;
  logic [7:0]  maddr_b, wdata_b, rdata_b;

  bit [7:0] mem_a [256];
  bit [7:0] mem_b [256];
  int       wcnt_a = 0;
  int       rcnt_a = 0;

  logic       pre_en = 1'b0;
  logic       pre_sel = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;

  int checks = 0;
  int errors = 0;

  logic        tr_re   [1:10];
  logic        tr_we   [1:10];
  logic        tr_busy [1:10];
  logic [7:0]  tr_addr [1:10];
  logic [7:0]  tr_wd   [1:10];
  int          done_cyc;
  logic        end_err;
  logic [31:0] end_ld;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8), .ALLOW_MISALIGNED(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .is_load(is_load), .is_store(is_store),
    .func3(func3), .addr(addr), .store_data(store_data),
    .busy(busy_a), .done(done_a), .err(err_a), .load_data(ld_a),
    .mem_addr(maddr_a), .mem_re(re_a), .mem_we(we_a), .mem_wdata(wdata_a),
    .mem_rdata(rdata_a)
  );

  load_store_unit #(.ADDR_W(8), .ALLOW_MISALIGNED(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .is_load(is_load), .is_store(is_store),
    .func3(func3), .addr(addr), .store_data(store_data),
    .busy(busy_b), .done(done_b), .err(err_b), .load_data(ld_b),
    .mem_addr(maddr_b), .mem_re(re_b), .mem_we(we_b), .mem_wdata(wdata_b),
    .mem_rdata(rdata_b)
  );

  // Byte memories: combinational read, write on the clock edge, plus a
  // preload port driven by the bench.
  assign rdata_a = mem_a[maddr_a];
  assign rdata_b = mem_b[maddr_b];

  always @(posedge clk) begin
    if (we_a) begin
      mem_a[maddr_a] <= wdata_a;
      wcnt_a <= wcnt_a + 1;
    end
    if (re_a) rcnt_a <= rcnt_a + 1;
    if (we_b) mem_b[maddr_b] <= wdata_b;
    if (pre_en && !pre_sel) mem_a[pre_addr] <= pre_data;
    if (pre_en && pre_sel)  mem_b[pre_addr] <= pre_data;
  end

  task automatic poke(input bit sel, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_sel = sel; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Issues one request (cycle 0) and records cycles 1.. until done or a bound.
  task automatic run_req(input bit sel, input bit ld, input bit st,
                         input logic [2:0] f3, input logic [7:0] a, input logic [31:0] d);
    for (int c = 1; c <= 10; c++) begin
      tr_re[c] = 1'b0; tr_we[c] = 1'b0; tr_busy[c] = 1'b0;
      tr_addr[c] = 8'h00; tr_wd[c] = 8'h00;
    end
    @(posedge clk); #1;
    is_load = ld; is_store = st; func3 = f3; addr = a; store_data = d;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      tr_re[c]   = sel ? re_b    : re_a;
      tr_we[c]   = sel ? we_b    : we_a;
      tr_busy[c] = sel ? busy_b  : busy_a;
      tr_addr[c] = sel ? maddr_b : maddr_a;
      tr_wd[c]   = sel ? wdata_b : wdata_a;
      if ((sel ? done_b : done_a) === 1'b1) begin
        done_cyc = c;
        end_err  = sel ? err_b : err_a;
        end_ld   = sel ? ld_b  : ld_a;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    is_load = 1'b0; is_store = 1'b0; func3 = 3'b000; addr = 8'h00; store_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, err_a, re_a, we_a} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy_a, done_a, err_a, re_a, we_a});
    end
    checks++;
    if (maddr_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00", maddr_a); end
    checks++;
    if (wdata_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 00", wdata_a); end
    checks++;
    if (ld_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_load_data: got %h expected 00000000", ld_a); end
    rst = 1'b0;
  endtask

  task automatic test_load_word();
    poke(1'b0, 8'h00, 8'h11);
    run_req(1'b0, 1'b1, 1'b0, 3'b010, 8'h00, 32'h0);
    checks++;
    if (done_cyc !== 5) begin errors++; $display("[TB] FAIL lw_done_cycle: got %0d expected 5", done_cyc); end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({tr_re[c], tr_we[c], tr_addr[c]} !== {1'b1, 1'b0, 8'(c - 1)}) begin
        errors++;
        $display("[TB] FAIL lw_access_c%0d: got re=%b we=%b addr=%h expected re=1 we=0 addr=%h",
                 c, tr_re[c], tr_we[c], tr_addr[c], 8'(c - 1));
      end
    end
    checks++;
    if (end_ld !== 32'h00000011) begin errors++; $display("[TB] FAIL lw_data: got %h expected 00000011", end_ld); end
    checks++;
    if (end_err !== 1'b0) begin errors++; $display("[TB] FAIL lw_err: got %b expected 0", end_err); end
    checks++;
    if ({tr_re[5], tr_we[5], tr_busy[5]} !== 3'b001) begin
      errors++; $display("[TB] FAIL lw_done_ctrl: got %b expected 001", {tr_re[5], tr_we[5], tr_busy[5]});
    end
  endtask

  task automatic test_byte();
    int w0;
    w0 = wcnt_a;
    run_req(1'b0, 1'b0, 1'b1, 3'b000, 8'h05, 32'hDEADBEEF);
    checks++;
    if (done_cyc !== 2) begin errors++; $display("[TB] FAIL sb_done_cycle: got %0d expected 2", done_cyc); end
    checks++;
    if ({tr_we[1], tr_re[1], tr_addr[1], tr_wd[1]} !== {1'b1, 1'b0, 8'h05, 8'hEF}) begin
      errors++; $display("[TB] FAIL sb_access: got we=%b re=%b addr=%h wd=%h expected 1 0 05 ef",
                         tr_we[1], tr_re[1], tr_addr[1], tr_wd[1]);
    end
    checks++;
    if ((wcnt_a - w0) !== 1) begin errors++; $display("[TB] FAIL sb_write_count: got %0d expected 1", wcnt_a - w0); end
    checks++;
    if (mem_a[5] !== 8'hEF) begin errors++; $display("[TB] FAIL sb_mem: got %h expected ef", mem_a[5]); end
    run_req(1'b0, 1'b1, 1'b0, 3'b100, 8'h05, 32'h0);
    checks++;
    if (end_ld !== 32'h000000EF) begin errors++; $display("[TB] FAIL lbu_data: got %h expected 000000ef", end_ld); end
    run_req(1'b0, 1'b1, 1'b0, 3'b000, 8'h05, 32'h0);
    checks++;
    if (end_ld !== 32'hFFFFFFEF) begin errors++; $display("[TB] FAIL lb_data: got %h expected ffffffef", end_ld); end
  endtask

  task automatic test_half();
    run_req(1'b0, 1'b0, 1'b1, 3'b001, 8'h10, 32'h00008001);
    checks++;
    if (done_cyc !== 3) begin errors++; $display("[TB] FAIL sh_done_cycle: got %0d expected 3", done_cyc); end
    checks++;
    if ({tr_addr[1], tr_wd[1], tr_addr[2], tr_wd[2]} !== 32'h10_01_11_80) begin
      errors++; $display("[TB] FAIL sh_access: got %h expected 10011180",
                         {tr_addr[1], tr_wd[1], tr_addr[2], tr_wd[2]});
    end
    checks++;
    if ({mem_a[8'h11], mem_a[8'h10]} !== 16'h8001) begin
      errors++; $display("[TB] FAIL sh_mem: got %h expected 8001", {mem_a[8'h11], mem_a[8'h10]});
    end
    run_req(1'b0, 1'b1, 1'b0, 3'b001, 8'h10, 32'h0);
    checks++;
    if (end_ld !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL lh_data: got %h expected ffff8001", end_ld); end
    run_req(1'b0, 1'b1, 1'b0, 3'b101, 8'h10, 32'h0);
    checks++;
    if (end_ld !== 32'h00008001) begin errors++; $display("[TB] FAIL lhu_data: got %h expected 00008001", end_ld); end
  endtask

  task automatic test_errors();
    int w0, r0;
    w0 = wcnt_a; r0 = rcnt_a;
    run_req(1'b0, 1'b1, 1'b0, 3'b010, 8'h02, 32'h0);
    checks++;
    if ({done_cyc == 1, end_err, tr_re[1], tr_we[1]} !== 4'b1100) begin
      errors++; $display("[TB] FAIL misaligned_lw: got done_cyc=%0d err=%b re=%b we=%b expected 1 1 0 0",
                         done_cyc, end_err, tr_re[1], tr_we[1]);
    end
    checks++;
    if (end_ld !== 32'h00008001) begin errors++; $display("[TB] FAIL err_holds_data: got %h expected 00008001", end_ld); end
    run_req(1'b0, 1'b1, 1'b0, 3'b011, 8'h00, 32'h0);
    checks++;
    if ({done_cyc == 1, end_err, tr_re[1], tr_we[1]} !== 4'b1100) begin
      errors++; $display("[TB] FAIL illegal_f3_011: got done_cyc=%0d err=%b re=%b we=%b expected 1 1 0 0",
                         done_cyc, end_err, tr_re[1], tr_we[1]);
    end
    run_req(1'b0, 1'b0, 1'b1, 3'b100, 8'h00, 32'h0);
    checks++;
    if ({done_cyc == 1, end_err} !== 2'b11) begin
      errors++; $display("[TB] FAIL illegal_store_f3: got done_cyc=%0d err=%b expected 1 1", done_cyc, end_err);
    end
    run_req(1'b0, 1'b1, 1'b1, 3'b000, 8'h00, 32'h0);
    checks++;
    if ({done_cyc == 1, end_err} !== 2'b11) begin
      errors++; $display("[TB] FAIL load_and_store: got done_cyc=%0d err=%b expected 1 1", done_cyc, end_err);
    end
    checks++;
    if ({wcnt_a - w0, rcnt_a - r0} !== {32'd0, 32'd0}) begin
      errors++; $display("[TB] FAIL err_no_access: got writes=%0d reads=%0d expected 0 0", wcnt_a - w0, rcnt_a - r0);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr [1:4];
    logic [7:0] exp_wd   [1:4];
    exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01; exp_addr[4] = 8'h02;
    exp_wd[1]   = 8'hDD; exp_wd[2]   = 8'hCC; exp_wd[3]   = 8'hBB; exp_wd[4]   = 8'hAA;
    run_req(1'b1, 1'b0, 1'b1, 3'b010, 8'hFF, 32'hAABBCCDD);
    checks++;
    if ({done_cyc == 5, end_err} !== 2'b10) begin
      errors++; $display("[TB] FAIL wrap_done: got done_cyc=%0d err=%b expected 5 0", done_cyc, end_err);
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({tr_we[c], tr_re[c], tr_addr[c], tr_wd[c]} !== {1'b1, 1'b0, exp_addr[c], exp_wd[c]}) begin
        errors++; $display("[TB] FAIL wrap_access_c%0d: got we=%b re=%b addr=%h wd=%h expected 1 0 %h %h",
                           c, tr_we[c], tr_re[c], tr_addr[c], tr_wd[c], exp_addr[c], exp_wd[c]);
      end
    end
    checks++;
    if ({tr_busy[1], tr_busy[2], tr_busy[3], tr_busy[4], tr_busy[5]} !== 5'b11111) begin
      errors++; $display("[TB] FAIL wrap_busy: got %b expected 11111",
                         {tr_busy[1], tr_busy[2], tr_busy[3], tr_busy[4], tr_busy[5]});
    end
    checks++;
    if ({mem_b[8'h02], mem_b[8'h01], mem_b[8'h00], mem_b[8'hFF]} !== 32'hAABBCCDD) begin
      errors++; $display("[TB] FAIL wrap_mem: got %h expected aabbccdd",
                         {mem_b[8'h02], mem_b[8'h01], mem_b[8'h00], mem_b[8'hFF]});
    end
  endtask

  task automatic test_reset_mid_xfer();
    @(posedge clk); #1;
    is_load = 1'b0; is_store = 1'b1; func3 = 3'b010; addr = 8'h20; store_data = 32'h44332211;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({we_a, maddr_a} !== {1'b1, 8'h21}) begin
      errors++; $display("[TB] FAIL mid_second_xfer: got we=%b addr=%h expected 1 21", we_a, maddr_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy_a, done_a, err_a, re_a, we_a, maddr_a, wdata_a} !== 21'h0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got %h expected 000000",
                         {busy_a, done_a, err_a, re_a, we_a, maddr_a, wdata_a});
    end
    checks++;
    if ({mem_a[8'h22], mem_a[8'h21], mem_a[8'h20]} !== 24'h00_22_11) begin
      errors++; $display("[TB] FAIL mid_reset_mem: got %h expected 002211",
                         {mem_a[8'h22], mem_a[8'h21], mem_a[8'h20]});
    end
    run_req(1'b0, 1'b1, 1'b0, 3'b000, 8'h20, 32'h0);
    checks++;
    if ({done_cyc == 2, end_err, end_ld} !== {1'b1, 1'b0, 32'h00000011}) begin
      errors++; $display("[TB] FAIL post_reset_lb: got done_cyc=%0d err=%b data=%h expected 2 0 00000011",
                         done_cyc, end_err, end_ld);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_word();
    test_byte();
    test_half();
    test_errors();
    test_wrap();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
